// File: rtl/id_ctrl_issue.sv
// ID-stage issue controller for the MIPS-Lite pipeline.
// Decodes the IF/ID instruction into WB/MEM/EX control bundles, stalls on load-use and
// multiplier-busy hazards by emitting a bubble and freezing PC/IF-ID, tracks the in-flight
// multiply with a down-counter and keeps a saturating count of bubble cycles.
module id_ctrl_issue #(
  parameter int unsigned MUL_LAT     = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr,
  input  logic                   id_ex_mem_read,
  input  logic [4:0]             id_ex_rt,
  input  logic                   flush,
  output logic [1:0]             WB,
  output logic [1:0]             MEM,
  output logic [4:0]             EX,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   mul_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // MUL_LAT is at most 255, so an 8-bit counter covers every legal setting.
  localparam int unsigned CntW = 8;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;

  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic [1:0] wb_dec, mem_dec;
  logic [4:0] ex_dec;
  logic       use_rs, use_rt, is_rtype;
  logic       load_use, mul_hazard, hazard, issue, multu_issue, stall_cycle;

  // rd and shamt only matter downstream of ID.
  logic unused_fields;
  assign unused_fields = ^instr[15:6];

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign funct  = instr[5:0];

  // Opcode decode: control bundles plus which source registers the instruction reads.
  always_comb begin
    wb_dec   = 2'b00;
    mem_dec  = 2'b00;
    ex_dec   = 5'b00000;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_rtype = 1'b0;
    case (opcode)
      OpRtype: begin
        wb_dec   = 2'b10;
        ex_dec   = 5'b01010;
        is_rtype = 1'b1;
        use_rt   = 1'b1;
        // Shifts carry the shift amount in shamt; rs is not a source.
        use_rs   = !(funct == FnSll || funct == FnSrl);
      end
      OpLw: begin
        wb_dec  = 2'b11;
        mem_dec = 2'b10;
        ex_dec  = 5'b10000;
        use_rs  = 1'b1;
      end
      OpSw: begin
        mem_dec = 2'b01;
        ex_dec  = 5'b10000;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
      end
      OpBeq: begin
        ex_dec = 5'b00001;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OpAddiu: begin
        wb_dec = 2'b10;
        ex_dec = 5'b10000;
        use_rs = 1'b1;
      end
      OpAndi: begin
        wb_dec = 2'b10;
        ex_dec = 5'b10011;
        use_rs = 1'b1;
      end
      OpOri: begin
        wb_dec = 2'b10;
        ex_dec = 5'b10100;
        use_rs = 1'b1;
      end
      OpSlti: begin
        wb_dec = 2'b10;
        ex_dec = 5'b10101;
        use_rs = 1'b1;
      end
      default: ;  // j and unknown opcodes issue as NOP
    endcase
  end

  // Hazard detection and issue qualification.
  always_comb begin
    load_use    = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                  ((use_rs && (rs == id_ex_rt)) || (use_rt && (rt == id_ex_rt)));
    mul_hazard  = (state_q == StBusy) && is_rtype &&
                  (funct == FnMultu || funct == FnMfhi || funct == FnMflo);
    hazard      = load_use || mul_hazard;
    issue       = rst && !flush && !hazard;
    multu_issue = issue && is_rtype && (funct == FnMultu);
    stall_cycle = rst && !flush && hazard;
  end

  // State register: multiply FSM, latency counter and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Next-state: arm on an issued multu, count down, drop back to idle as the count hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    unique case (state_q)
      StIdle: begin
        if (multu_issue) begin
          state_d = StBusy;
          cnt_d   = CntW'(MUL_LAT);
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (stall_cycle && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // Outputs: flush beats hazards, hazards beat issue; everything quiet while in reset.
  always_comb begin
    WB          = 2'b00;
    MEM         = 2'b00;
    EX          = 5'b00000;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    mul_busy    = (state_q == StBusy);
    stall_cnt   = stall_q;
    if (rst) begin
      if (flush) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end else if (!hazard) begin
        WB          = wb_dec;
        MEM         = mem_dec;
        EX          = ex_dec;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ctrl_issue.sv
module tb_id_ctrl_issue;

  localparam int unsigned MulLat = 4;
  localparam int unsigned StW    = 4;

  localparam logic [31:0] ILw     = 32'h8D090000;  // lw    $t1,0($t0)
  localparam logic [31:0] IAdd    = 32'h012B5020;  // add   $t2,$t1,$t3
  localparam logic [31:0] IMultu  = 32'h012B0019;  // multu $t1,$t3
  localparam logic [31:0] IMflo   = 32'h00005012;  // mflo  $t2
  localparam logic [31:0] IMfhi   = 32'h00005010;  // mfhi  $t2
  localparam logic [31:0] INop    = 32'h00000000;

  logic            clk, rst, id_ex_mem_read, flush;
  logic [31:0]     instr;
  logic [4:0]      id_ex_rt;
  logic [1:0]      wb, mem;
  logic [4:0]      ex;
  logic            pc_write, if_id_write, mul_busy;
  logic [StW-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  id_ctrl_issue #(
    .MUL_LAT    (MulLat),
    .STALL_CNT_W(StW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt      (id_ex_rt),
    .flush         (flush),
    .WB            (wb),
    .MEM           (mem),
    .EX            (ex),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .mul_busy      (mul_busy),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks happen 1 time unit later.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = 5'd0; instr = INop;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b0; flush = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = 5'd0; instr = ILw;
    @(negedge clk);
    #1;
    obs = {wb, mem, ex, pc_write, if_id_write, mul_busy, stall_cnt != 0};
    checks++;
    if (obs !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = {wb, mem, ex, pc_write, if_id_write, mul_busy, 1'b0};
    checks++;
    if (obs !== 13'b11_10_10000_1_1_0_0) begin
      failures++;
      $display("FAIL lw_after_reset got=%b want=%b", obs, 13'b11_10_10000_1_1_0_0);
    end
  endtask

  task automatic test_decode();
    logic [31:0] vi [10];
    logic [8:0]  ve [10];
    logic [10:0] obs, exp;
    vi[0] = IAdd;         ve[0] = 9'b10_00_01010;
    vi[1] = ILw;          ve[1] = 9'b11_10_10000;
    vi[2] = 32'hAD090004; ve[2] = 9'b00_01_10000;  // sw
    vi[3] = 32'h11090003; ve[3] = 9'b00_00_00001;  // beq
    vi[4] = 32'h252A0005; ve[4] = 9'b10_00_10000;  // addiu
    vi[5] = 32'h312A00FF; ve[5] = 9'b10_00_10011;  // andi
    vi[6] = 32'h352A00FF; ve[6] = 9'b10_00_10100;  // ori
    vi[7] = 32'h292A0005; ve[7] = 9'b10_00_10101;  // slti
    vi[8] = 32'h08000010; ve[8] = 9'b00_00_00000;  // j
    vi[9] = 32'h3C0A1234; ve[9] = 9'b00_00_00000;  // lui, unlisted
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr = vi[i];
      #1;
      obs = {wb, mem, ex, pc_write, if_id_write};
      exp = {ve[i], 2'b11};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL decode[%0d] instr=%h got=%b want=%b", i, vi[i], obs, exp);
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] si [8];
    logic [4:0]  sr [8];
    logic        ss [8];
    do_reset();
    @(negedge clk);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; instr = IAdd;
    #1;
    checks++;
    if ({wb, mem, ex, pc_write, if_id_write, stall_cnt} !== {13'd0, 4'd0}) begin
      failures++;
      $display("FAIL load_use_bubble got=%b%b%b pc=%b ifid=%b cnt=%0d want=0 cnt=0",
               wb, mem, ex, pc_write, if_id_write, stall_cnt);
    end
    @(negedge clk);
    id_ex_mem_read = 1'b0;
    #1;
    checks++;
    if ({stall_cnt, wb, ex, pc_write} !== {4'd1, 2'b10, 5'b01010, 1'b1}) begin
      failures++;
      $display("FAIL load_use_release cnt=%0d wb=%b ex=%b pc=%b want cnt=1 wb=10 ex=01010 pc=1",
               stall_cnt, wb, ex, pc_write);
    end
    // $zero as the load target never stalls.
    @(negedge clk);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0;
    #1;
    checks++;
    if ({pc_write, ex} !== {1'b1, 5'b01010}) begin
      failures++;
      $display("FAIL load_use_rt0 pc=%b ex=%b want pc=1 ex=01010", pc_write, ex);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL load_use_rt0_cnt got=%0d want=1", stall_cnt);
    end
    // Source-register usage per instruction class, load target $t1 (or $t0).
    si[0] = 32'h01205080; sr[0] = 5'd9; ss[0] = 1'b0;  // sll, rs field ignored
    si[1] = 32'h00095080; sr[1] = 5'd9; ss[1] = 1'b1;  // sll reads rt
    si[2] = 32'hAD090004; sr[2] = 5'd9; ss[2] = 1'b1;  // sw reads rt
    si[3] = 32'h11090003; sr[3] = 5'd8; ss[3] = 1'b1;  // beq reads rs
    si[4] = 32'h25090005; sr[4] = 5'd9; ss[4] = 1'b0;  // addiu rt is a destination
    si[5] = 32'h252A0005; sr[5] = 5'd9; ss[5] = 1'b1;  // addiu reads rs
    si[6] = 32'h09290000; sr[6] = 5'd9; ss[6] = 1'b0;  // j reads nothing
    si[7] = IAdd;         sr[7] = 5'd11; ss[7] = 1'b1; // R-type reads rt
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      id_ex_mem_read = 1'b1; id_ex_rt = sr[i]; instr = si[i];
      #1;
      checks++;
      if ({pc_write, if_id_write} !== {2{!ss[i]}}) begin
        failures++;
        $display("FAIL src_regs[%0d] instr=%h pc=%b ifid=%b want=%b", i, si[i], pc_write,
                 if_id_write, !ss[i]);
      end
    end
    id_ex_mem_read = 1'b0;
  endtask

  task automatic test_multiply();
    do_reset();
    @(negedge clk);
    instr = IMultu;
    #1;
    checks++;
    if ({pc_write, ex, mul_busy} !== {1'b1, 5'b01010, 1'b0}) begin
      failures++;
      $display("FAIL multu_issue pc=%b ex=%b busy=%b want pc=1 ex=01010 busy=0",
               pc_write, ex, mul_busy);
    end
    @(negedge clk);
    instr = IMflo;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({mul_busy, pc_write, if_id_write, wb, mem, ex} !== {1'b1, 11'd0}) begin
        failures++;
        $display("FAIL mflo_stall[%0d] busy=%b pc=%b ifid=%b bundles=%b%b%b want busy=1 rest 0",
                 k, mul_busy, pc_write, if_id_write, wb, mem, ex);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({mul_busy, pc_write, wb, ex, stall_cnt} !== {1'b0, 1'b1, 2'b10, 5'b01010, 4'd4}) begin
      failures++;
      $display("FAIL mflo_issue busy=%b pc=%b wb=%b ex=%b cnt=%0d want 0 1 10 01010 4",
               mul_busy, pc_write, wb, ex, stall_cnt);
    end
    // Unrelated R-type flows while busy; mfhi does not.
    @(negedge clk);
    instr = IMultu;
    @(negedge clk);
    instr = IAdd;
    #1;
    checks++;
    if ({mul_busy, pc_write} !== 2'b11) begin
      failures++;
      $display("FAIL add_during_busy busy=%b pc=%b want busy=1 pc=1", mul_busy, pc_write);
    end
    @(negedge clk);
    instr = IMfhi;
    #1;
    checks++;
    if (pc_write !== 1'b0) begin
      failures++;
      $display("FAIL mfhi_stall pc=%b want 0", pc_write);
    end
    instr = INop;
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    flush = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; instr = IAdd;
    #1;
    checks++;
    if ({wb, mem, ex, pc_write, if_id_write} !== 11'b00_00_00000_1_1) begin
      failures++;
      $display("FAIL flush_over_hazard got=%b%b%b pc=%b ifid=%b want bundles 0 pc=1 ifid=1",
               wb, mem, ex, pc_write, if_id_write);
    end
    @(negedge clk);
    id_ex_mem_read = 1'b0; instr = IMultu;
    #1;
    checks++;
    if (stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL flush_no_count got=%0d want=0", stall_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mul_busy !== 1'b0) begin
      failures++;
      $display("FAIL flushed_multu busy=%b want 0", mul_busy);
    end
    // Flush arriving after the multiply started leaves it running.
    flush = 1'b0;
    @(negedge clk);
    flush = 1'b1; instr = INop;
    @(negedge clk);
    #1;
    checks++;
    if (mul_busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_keeps_busy busy=%b want 1", mul_busy);
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    @(negedge clk);
    instr = IMultu;
    @(negedge clk);
    instr = IMflo;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({mul_busy, stall_cnt, pc_write} !== 6'd0) begin
      failures++;
      $display("FAIL async_reset busy=%b cnt=%0d pc=%b want all 0", mul_busy, stall_cnt,
               pc_write);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({mul_busy, pc_write, ex} !== {1'b0, 1'b1, 5'b01010}) begin
      failures++;
      $display("FAIL mflo_after_reset busy=%b pc=%b ex=%b want 0 1 01010", mul_busy, pc_write,
               ex);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; instr = IAdd;
    repeat (15) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 4'hF) begin
      failures++;
      $display("FAIL stall_cnt_full got=%0d want=15", stall_cnt);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 4'hF) begin
      failures++;
      $display("FAIL stall_cnt_saturate got=%0d want=15", stall_cnt);
    end
    id_ex_mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_multiply();
    test_flush();
    test_reset_mid_busy();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ctrl_issue.md
Name: id_ctrl_issue

Overview:
- ID-stage issue controller for the pipelined MIPS-Lite CPU. It produces the packed WB/MEM/EX control bundles that the ID/EX pipeline register consumes.
- Decodes the IF/ID instruction, detects load-use and multiply-busy hazards, and inserts bubbles by zeroing the bundles while holding PC and IF/ID.
- Tracks the in-flight multiplier with a busy counter and keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 32, cycles the multiplier is busy after multu leaves ID (legal range 2..255)
STALL_CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
instr  input  32  instruction held in IF/ID
id_ex_mem_read  input  1  MemRead bit of the instruction currently in ID/EX (its MEM[1])
id_ex_rt  input  5  rt field of the instruction currently in ID/EX
flush  input  1  branch/jump redirect; squash the instruction in ID
WB  output  2  [1]=RegWrite, [0]=MemtoReg
MEM  output  2  [1]=MemRead, [0]=MemWrite
EX  output  5  [4]=ALUSrc, [3]=RegDst, [2:0]=ALUOp
pc_write  output  1  1 = PC may update
if_id_write  output  1  1 = IF/ID may load
mul_busy  output  1  multiplier result not yet available
stall_cnt  output  STALL_CNT_W  saturating count of hazard-bubble cycles

Behaviour:
- Reset: clk and rst are the only clocking/reset ports; reset is asynchronous and active-low. While rst=0:
  - state IDLE, busy counter 0, stall_cnt 0;
  - WB, MEM, EX all 0;
  - pc_write=0, if_id_write=0, mul_busy=0.
- Decode (combinational from instr[31:26]):
  - R-type 000000: WB=10, MEM=00, EX=0_1_010.
  - lw 100011: WB=11, MEM=10, EX=1_0_000.
  - sw 101011: WB=00, MEM=01, EX=1_0_000.
  - beq 000100: WB=00, MEM=00, EX=0_0_001.
  - addiu 001001: WB=10, EX=1_0_000.
  - andi 001100: WB=10, EX=1_0_011.
  - ori 001101: WB=10, EX=1_0_100.
  - slti 001010: WB=10, EX=1_0_101.
  - j 000010, and any unlisted opcode: all bundles 0 (NOP).
- Source registers:
  - R-type and beq read rs and rt; sll/srl (funct 000000/000010) read rt only.
  - sw reads rs and rt.
  - lw and the immediate ops read rs.
  - j reads nothing.
- Load-use hazard: id_ex_mem_read=1, id_ex_rt!=0, and id_ex_rt equals a source register of instr.
- Multiply hazard: mul_busy=1 and instr is R-type with funct multu 011001, mfhi 010000 or mflo 010010.
- Priority, evaluated each cycle with rst=1:
  1. flush=1: bundles 0, pc_write=1, if_id_write=1. No stall_cnt increment. A squashed multu does not start the counter.
  2. Else any hazard: bundles 0 (bubble), pc_write=0, if_id_write=0. stall_cnt increments at the next edge, saturating at all-ones.
  3. Else issue: decoded bundles, pc_write=1, if_id_write=1.
- Multiply FSM, states IDLE and BUSY:
  - IDLE→BUSY at the edge where a multu issues under rule 3; the counter loads MUL_LAT.
  - In BUSY the counter decrements each edge. BUSY→IDLE on the edge where the counter goes 1→0.
  - mul_busy = (state==BUSY), registered. It is 1 for exactly MUL_LAT cycles after the multu issue edge.
  - flush does not cancel a multiply already in BUSY.
- Latency: decode and hazard outputs are combinational, 0 cycles. State, mul_busy and stall_cnt update on the rising edge only.
- Reset asserted mid-BUSY: immediately IDLE, mul_busy=0, counter 0. A stalled mflo issues on the first cycle after release.

Test Plan:
- Reset release, instr=lw $t1,0($t0) (0x8D090000), no hazard → WB=11, MEM=10, EX=10000, pc_write=1, if_id_write=1.
- id_ex_mem_read=1, id_ex_rt=9, instr=add $t2,$t1,$t3 → one cycle with bundles 0, pc_write=0, stall_cnt 0→1. Next cycle id_ex_mem_read=0 → add issues with EX=01010.
- Same as above but id_ex_rt=0 → no stall.
- MUL_LAT=4: multu issued, then mflo in ID → mul_busy=1 for 4 cycles, mflo stalled 4 cycles, stall_cnt=4, mflo issues in cycle 5.
- flush=1 coincident with a load-use hazard → bundles 0, pc_write=1, stall_cnt unchanged. flush on a multu → mul_busy stays 0.
- rst driven low 2 cycles into BUSY → mul_busy drops asynchronously, stall_cnt=0. Force stall_cnt to all-ones, hold a stall → value stays all-ones.
